// File: rtl/step_scheduler.sv
`timescale 1ns/1ps
// step_scheduler
//   Sequences one game step of the snake datapath: waits one tick interval,
//   pulses the direction latch, handshakes a move with the snake body logic,
//   samples the food-hit flag, and optionally handshakes food regeneration.
//   It is the single source of step timing for the game.
//
// Optional feature (macro SPEEDUP_EN): the interval shrinks by SPEEDUP per
//   body segment beyond 3, clamped at TICK_MIN. Without the macro the
//   interval is exactly TICK_FAST or TICK_SLOW and snake_length is ignored.
//
// Ports
//   clk, rst        clock; asynchronous active-low reset
//   game_state[1:0] RUNNING=00, DIE=01, INITIAL=10
//   pause, slow     level inputs: freeze timer / select TICK_SLOW
//   snake_length    body length (only used with SPEEDUP_EN)
//   get_food        head-on-food flag, sampled in CHECK
//   move_ack        snake finished the shift/grow
//   food_ack        food generator placed new food
//   dir_latch       one-cycle pulse: snake latches next_direction
//   move_req        level request to advance the snake
//   food_req        level request to regenerate food
//   step_count      completed steps since INITIAL->RUNNING, saturating
//   busy            high in LATCH, MOVE, CHECK, FOOD
//   ack_err         sticky watchdog expiry flag
//   state_dbg       current FSM state encoding
//
// Handshake: a request (move_req / food_req) rises on state entry and stays
// high until the matching ack is sampled high on a rising clock edge; it is
// never withdrawn early except by watchdog expiry or reset. An ack arriving
// in the same cycle as watchdog expiry is honoured.
module step_scheduler #(
  parameter int TICK_FAST   = 5000000,
  parameter int TICK_SLOW   = 10000000,
  parameter int TICK_MIN    = 1000000,
  parameter int SPEEDUP     = 250000,
  parameter int ACK_TIMEOUT = 1023,
  parameter int CNT_W       = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  game_state,
  input  logic        pause,
  input  logic        slow,
  input  logic [5:0]  snake_length,
  input  logic        get_food,
  input  logic        move_ack,
  input  logic        food_ack,
  output logic        dir_latch,
  output logic        move_req,
  output logic        food_req,
  output logic [15:0] step_count,
  output logic        busy,
  output logic        ack_err,
  output logic [2:0]  state_dbg
);

  localparam logic [1:0] GS_RUNNING = 2'b00;
  localparam logic [1:0] GS_INITIAL = 2'b10;
  localparam int WD_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_LATCH = 3'd2,
    S_MOVE  = 3'd3,
    S_CHECK = 3'd4,
    S_FOOD  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [15:0]      steps_q, steps_d;
  logic             err_q, err_d;
  logic [1:0]       prev_gs_q, prev_gs_d;
  logic [CNT_W-1:0] interval;
  logic             running, tick, leave, count;

`ifdef SPEEDUP_EN
  // Wide intermediate so (length-3)*SPEEDUP cannot wrap before the clamp.
  localparam int CALC_W = CNT_W + 6;
  logic [CALC_W-1:0] len_m3, reduction, base_ext, min_ext;
  always_comb begin
    len_m3    = (snake_length < 6'd3) ? '0 : CALC_W'(snake_length - 6'd3);
    reduction = len_m3 * CALC_W'(SPEEDUP);
    base_ext  = slow ? CALC_W'(TICK_SLOW) : CALC_W'(TICK_FAST);
    min_ext   = CALC_W'(TICK_MIN);
    if (base_ext <= reduction + min_ext) interval = CNT_W'(min_ext);
    else                                 interval = CNT_W'(base_ext - reduction);
  end
`else
  localparam int unused_speedup_cfg = TICK_MIN + SPEEDUP;
  logic unused_len;
  assign unused_len = ^snake_length;
  assign interval   = slow ? CNT_W'(TICK_SLOW) : CNT_W'(TICK_FAST);
`endif

  assign running = (game_state == GS_RUNNING);
  // Compared against the live counter, so a shorter interval selected
  // mid-count fires on the next unpaused cycle.
  assign tick    = !pause && (cnt_q >= interval - CNT_W'(1));
  assign prev_gs_d = game_state;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wd_d    = '0;
    steps_d = steps_q;
    err_d   = err_q;
    leave   = 1'b0;
    count   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (running) begin
          state_d = S_WAIT;
          cnt_d   = '0;
          if (prev_gs_q == GS_INITIAL) steps_d = '0;
        end
      end
      S_WAIT: begin
        if (!running) begin
          state_d = S_IDLE;
        end else if (tick) begin
          state_d = S_LATCH;
          cnt_d   = '0;
        end else if (!pause) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LATCH: state_d = S_MOVE;
      S_MOVE: begin
        if (move_ack) begin
          state_d = S_CHECK;
        end else if (wd_q == WD_LAST) begin
          err_d = 1'b1;
          leave = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_CHECK: begin
        if (get_food) state_d = S_FOOD;
        else begin
          leave = 1'b1;
          count = 1'b1;
        end
      end
      S_FOOD: begin
        if (food_ack) begin
          leave = 1'b1;
          count = 1'b1;
        end else if (wd_q == WD_LAST) begin
          err_d = 1'b1;
          leave = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (count && (steps_q != 16'hFFFF)) steps_d = steps_q + 16'd1;
    if (leave) begin
      state_d = running ? S_WAIT : S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wd_q      <= '0;
      steps_q   <= '0;
      err_q     <= 1'b0;
      prev_gs_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wd_q      <= wd_d;
      steps_q   <= steps_d;
      err_q     <= err_d;
      prev_gs_q <= prev_gs_d;
    end
  end

  assign dir_latch  = (state_q == S_LATCH);
  assign move_req   = (state_q == S_MOVE);
  assign food_req   = (state_q == S_FOOD);
  assign busy       = (state_q == S_LATCH) || (state_q == S_MOVE) ||
                      (state_q == S_CHECK) || (state_q == S_FOOD);
  assign step_count = steps_q;
  assign ack_err    = err_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_step_scheduler.sv
`timescale 1ns/1ps
module tb_step_scheduler;

  localparam logic [1:0] GS_RUNNING = 2'b00;
  localparam logic [1:0] GS_DIE     = 2'b01;
  localparam logic [1:0] GS_INITIAL = 2'b10;
  localparam logic [2:0] ST_IDLE    = 3'd0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  game_state = GS_INITIAL;
  logic        pause = 1'b0, slow = 1'b0, get_food = 1'b0;
  logic [5:0]  snake_length = 6'd3;
  logic        move_ack, food_ack;
  logic        dir_latch, move_req, food_req, busy, ack_err;
  logic [15:0] step_count;
  logic [2:0]  state_dbg;

  int errors = 0;
  int checks = 0;
  int exp_steps = 0;

  int move_ack_after = 3;
  int food_ack_after = 3;
  int mcnt, fcnt, mlen, flen;
  bit food_seen;

  step_scheduler #(
    .TICK_FAST(8), .TICK_SLOW(16), .TICK_MIN(4), .SPEEDUP(1),
    .ACK_TIMEOUT(16), .CNT_W(8)
  ) u_dut (
    .clk(clk), .rst(rst), .game_state(game_state), .pause(pause), .slow(slow),
    .snake_length(snake_length), .get_food(get_food), .move_ack(move_ack),
    .food_ack(food_ack), .dir_latch(dir_latch), .move_req(move_req),
    .food_req(food_req), .step_count(step_count), .busy(busy),
    .ack_err(ack_err), .state_dbg(state_dbg)
  );

`ifdef SPEEDUP_EN
  logic [5:0]  sp_len = 6'd3;
  logic        sp_latch, sp_move_req, sp_food_req, sp_busy, sp_err;
  logic [15:0] sp_steps;
  logic [2:0]  sp_state;
  step_scheduler #(
    .TICK_FAST(100), .TICK_SLOW(200), .TICK_MIN(40), .SPEEDUP(10),
    .ACK_TIMEOUT(16), .CNT_W(8)
  ) u_sp (
    .clk(clk), .rst(rst), .game_state(GS_RUNNING), .pause(1'b0), .slow(1'b0),
    .snake_length(sp_len), .get_food(1'b0), .move_ack(sp_move_req),
    .food_ack(1'b0), .dir_latch(sp_latch), .move_req(sp_move_req),
    .food_req(sp_food_req), .step_count(sp_steps), .busy(sp_busy),
    .ack_err(sp_err), .state_dbg(sp_state)
  );
`endif

  // ---------------- snake / food responders ----------------
  // Ack is raised during the N-th cycle a request has been high (0 = never);
  // the length of each finished request is recorded.
  initial begin
    mcnt = 0; fcnt = 0; mlen = 0; flen = 0; food_seen = 0;
    move_ack = 1'b0; food_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (move_req === 1'b1) begin
        mcnt++;
        move_ack = (mcnt == move_ack_after);
      end else begin
        if (mcnt != 0) mlen = mcnt;
        mcnt = 0;
        move_ack = 1'b0;
      end
      if (food_req === 1'b1) begin
        food_seen = 1;
        fcnt++;
        food_ack = (fcnt == food_ack_after);
      end else begin
        if (fcnt != 0) flen = fcnt;
        fcnt = 0;
        food_ack = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_latch(input int budget, output int cycles, output bit ok);
    ok = 0; cycles = 0;
    while (!ok && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (dir_latch === 1'b1) ok = 1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({dir_latch, move_req, food_req, busy, ack_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 00000", {dir_latch, move_req, food_req, busy, ack_err});
    end
    checks++;
    if (step_count !== 16'd0) begin
      errors++; $display("FAIL reset_steps: got %0d want 0", step_count);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (state_dbg !== ST_IDLE || busy !== 1'b0) begin
      errors++; $display("FAIL idle_initial: state %0d busy %b want 0 0", state_dbg, busy);
    end
  endtask

  task automatic test_basic_steps();
    int c; bit ok;
    move_ack_after = 3;
    game_state = GS_RUNNING;
    wait_latch(50, c, ok);
    checks++;
    if (!ok || c != 9 || step_count !== 16'd0) begin
      errors++; $display("FAIL first_latch: cycles %0d ok %0d steps %0d want 9 1 0", c, ok, step_count);
    end
    @(negedge clk);
    checks++;
    if (dir_latch !== 1'b0 || move_req !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL latch_to_move: latch %b req %b busy %b want 0 1 1", dir_latch, move_req, busy);
    end
    wait_latch(50, c, ok);
    exp_steps = 1;
    checks++;
    if (!ok || c != 12 || step_count !== 16'(exp_steps)) begin
      errors++; $display("FAIL period_1: cycles %0d steps %0d want 12 %0d", c, step_count, exp_steps);
    end
    for (int k = 2; k <= 3; k++) begin
      wait_latch(50, c, ok);
      exp_steps = k;
      checks++;
      if (!ok || c != 13 || step_count !== 16'(exp_steps)) begin
        errors++; $display("FAIL period_%0d: cycles %0d steps %0d want 13 %0d", k, c, step_count, exp_steps);
      end
    end
    checks++;
    if (mlen != 3 || food_seen) begin
      errors++; $display("FAIL move_len_nofood: len %0d food_seen %0d want 3 0", mlen, food_seen);
    end
  endtask

  task automatic test_length_ignored();
    int c; bit ok;
    snake_length = 6'd40;
    wait_latch(50, c, ok);
    exp_steps++;
    checks++;
    if (!ok || c != 13) begin
      errors++; $display("FAIL length_ignored: cycles %0d want 13", c);
    end
    snake_length = 6'd3;
  endtask

  task automatic test_food();
    int c; bit ok;
    get_food = 1'b1;
    food_ack_after = 3;
    wait_latch(60, c, ok);
    get_food = 1'b0;
    exp_steps++;
    checks++;
    if (!ok || c != 16 || step_count !== 16'(exp_steps)) begin
      errors++; $display("FAIL food_period: cycles %0d steps %0d want 16 %0d", c, step_count, exp_steps);
    end
    checks++;
    if (flen != 3) begin
      errors++; $display("FAIL food_req_len: got %0d want 3", flen);
    end
  endtask

  task automatic test_slow();
    int c; bit ok;
    slow = 1'b1;
    wait_latch(60, c, ok);
    exp_steps++;
    checks++;
    if (!ok || c != 21 || step_count !== 16'(exp_steps)) begin
      errors++; $display("FAIL slow_period: cycles %0d steps %0d want 21 %0d", c, step_count, exp_steps);
    end
    // counter reaches 12 under the slow interval, then fast is selected
    repeat (17) @(negedge clk);
    slow = 1'b0;
    wait_latch(30, c, ok);
    exp_steps++;
    checks++;
    if (!ok || c != 1) begin
      errors++; $display("FAIL slow_overshoot: cycles %0d want 1", c);
    end
  endtask

  task automatic test_pause();
    int c; bit ok; bit seen;
    seen = 0;
    repeat (9) @(negedge clk);
    pause = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (dir_latch === 1'b1) seen = 1;
    end
    pause = 1'b0;
    checks++;
    if (seen) begin
      errors++; $display("FAIL pause_hold: dir_latch seen 1 want 0");
    end
    wait_latch(30, c, ok);
    exp_steps++;
    checks++;
    if (!ok || c != 4 || step_count !== 16'(exp_steps)) begin
      errors++; $display("FAIL pause_resume: cycles %0d steps %0d want 4 %0d", c, step_count, exp_steps);
    end
  endtask

  task automatic test_ack_at_timeout();
    int c; bit ok;
    move_ack_after = 16;
    wait_latch(60, c, ok);
    exp_steps++;
    checks++;
    if (!ok || c != 26 || step_count !== 16'(exp_steps) || ack_err !== 1'b0) begin
      errors++; $display("FAIL ack_wins: cycles %0d steps %0d err %b want 26 %0d 0", c, step_count, ack_err, exp_steps);
    end
    checks++;
    if (mlen != 16) begin
      errors++; $display("FAIL ack_wins_len: got %0d want 16", mlen);
    end
  endtask

  task automatic test_timeout();
    int c; bit ok;
    move_ack_after = 0;
    wait_latch(60, c, ok);
    move_ack_after = 3;
    checks++;
    if (!ok || c != 25 || step_count !== 16'(exp_steps)) begin
      errors++; $display("FAIL timeout_period: cycles %0d steps %0d want 25 %0d", c, step_count, exp_steps);
    end
    checks++;
    if (mlen != 16 || ack_err !== 1'b1) begin
      errors++; $display("FAIL timeout_err: len %0d err %b want 16 1", mlen, ack_err);
    end
    wait_latch(60, c, ok);
    exp_steps++;
    checks++;
    if (!ok || c != 13 || step_count !== 16'(exp_steps) || ack_err !== 1'b1) begin
      errors++; $display("FAIL after_timeout: cycles %0d steps %0d err %b want 13 %0d 1", c, step_count, ack_err, exp_steps);
    end
  endtask

  task automatic test_die_mid_move();
    bit seen;
    seen = 0;
    @(negedge clk);
    checks++;
    if (move_req !== 1'b1) begin
      errors++; $display("FAIL die_req_up: move_req %b want 1", move_req);
    end
    game_state = GS_DIE;
    get_food = 1'b1;
    food_ack_after = 2;
    repeat (6) @(negedge clk);
    exp_steps++;
    checks++;
    if (state_dbg !== ST_IDLE || busy !== 1'b0 || step_count !== 16'(exp_steps)) begin
      errors++; $display("FAIL die_idle: state %0d busy %b steps %0d want 0 0 %0d", state_dbg, busy, step_count, exp_steps);
    end
    get_food = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (dir_latch === 1'b1) seen = 1;
    end
    checks++;
    if (seen || mlen != 3 || flen != 2) begin
      errors++; $display("FAIL die_drain: latch_seen %0d mlen %0d flen %0d want 0 3 2", seen, mlen, flen);
    end
  endtask

  task automatic test_step_clear();
    int c; bit ok;
    game_state = GS_RUNNING;
    wait_latch(50, c, ok);
    checks++;
    if (!ok || c != 9 || step_count !== 16'(exp_steps)) begin
      errors++; $display("FAIL die_resume_keep: cycles %0d steps %0d want 9 %0d", c, step_count, exp_steps);
    end
    game_state = GS_INITIAL;
    repeat (10) @(negedge clk);
    game_state = GS_RUNNING;
    wait_latch(50, c, ok);
    exp_steps = 0;
    checks++;
    if (!ok || c != 9 || step_count !== 16'(exp_steps)) begin
      errors++; $display("FAIL initial_clear: cycles %0d steps %0d want 9 0", c, step_count);
    end
  endtask

  task automatic test_reset_mid_step();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (move_req !== 1'b0 || ack_err !== 1'b0 || state_dbg !== ST_IDLE) begin
      errors++; $display("FAIL async_reset: req %b err %b state %0d want 0 0 0", move_req, ack_err, state_dbg);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

`ifdef SPEEDUP_EN
  task automatic wait_sp_latch(input int budget, output int cycles, output bit ok);
    ok = 0; cycles = 0;
    while (!ok && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (sp_latch === 1'b1) ok = 1;
    end
  endtask

  task automatic test_speedup();
    int c; bit ok;
    sp_len = 6'd5;
    wait_sp_latch(400, c, ok);
    wait_sp_latch(400, c, ok);
    checks++;
    if (!ok || c != 83) begin
      errors++; $display("FAIL speedup_len5: period %0d want 83", c);
    end
    sp_len = 6'd20;
    wait_sp_latch(400, c, ok);
    wait_sp_latch(400, c, ok);
    checks++;
    if (!ok || c != 43) begin
      errors++; $display("FAIL speedup_clamp: period %0d want 43", c);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic_steps();
`ifndef SPEEDUP_EN
    test_length_ignored();
`endif
    test_food();
    test_slow();
    test_pause();
    test_ack_at_timeout();
    test_timeout();
    test_die_mid_move();
    test_step_clear();
`ifdef SPEEDUP_EN
    test_speedup();
`endif
    test_reset_mid_step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
